// File: rtl/flow_control_fifo_queue.sv
// flow_control_fifo_queue
//   Single-clock request FIFO with arbitrary (non power-of-two) depth, occupancy count,
//   programmable almost-full watermark, synchronous flush and first-word-fall-through
//   registered head output (no bubble between back-to-back pops).
//
// Ports
//   clk_in, reset_in            clock, asynchronous active-high reset
//   flush_in                    synchronous flush, discards all entries
//   request_in/_valid_in        producer payload, held until issue_ack_out pulses
//   issue_ack_out               one-cycle pulse acknowledging an accepted write
//   request_out/_valid_out      registered head entry and its valid
//   issue_ack_in                consumer takes the head this cycle
//   is_empty_out, is_full_out,
//   almost_full_out,
//   occupancy_out               status, decoded from the count register only
module flow_control_fifo_queue #(
  parameter int unsigned SINGLE_ENTRY_WIDTH_IN_BITS = 512,
  parameter int unsigned QUEUE_SIZE                 = 16,
  parameter int unsigned QUEUE_PTR_WIDTH_IN_BITS    = 4,
  parameter int unsigned ALMOST_FULL_THRESHOLD      = QUEUE_SIZE - 2
) (
  input  logic                                  clk_in,
  input  logic                                  reset_in,
  input  logic                                  flush_in,
  input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_in,
  input  logic                                  request_valid_in,
  output logic                                  issue_ack_out,
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_out,
  output logic                                  request_valid_out,
  input  logic                                  issue_ack_in,
  output logic                                  is_empty_out,
  output logic                                  is_full_out,
  output logic                                  almost_full_out,
  output logic [QUEUE_PTR_WIDTH_IN_BITS:0]      occupancy_out
);

  localparam int unsigned W  = SINGLE_ENTRY_WIDTH_IN_BITS;
  localparam int unsigned PW = QUEUE_PTR_WIDTH_IN_BITS;
  localparam int unsigned CW = QUEUE_PTR_WIDTH_IN_BITS + 1;

  localparam logic [CW-1:0] DepthC   = CW'(QUEUE_SIZE);
  localparam logic [CW-1:0] ThreshC  = CW'(ALMOST_FULL_THRESHOLD);
  localparam logic [PW-1:0] LastIdxC = PW'(QUEUE_SIZE - 1);

  logic [W-1:0]  mem_q [QUEUE_SIZE];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  out_q, out_d;
  logic          valid_q, valid_d;
  logic          ack_q, ack_d;

  logic          pop, push;
  logic [CW-1:0] count_after_pop;

  // Wrap at QUEUE_SIZE-1 rather than at the pointer width, so any depth works.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LastIdxC) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    pop  = valid_q & issue_ack_in;
    // ~ack_q blocks re-accepting the request the producer is still holding this cycle.
    push = request_valid_in & ~ack_q & ~flush_in & ((count_q < DepthC) | pop);

    count_after_pop = count_q - {{PW{1'b0}}, pop};
    count_d         = count_after_pop + {{PW{1'b0}}, push};
    wr_ptr_d        = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d        = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    ack_d           = push;
    valid_d         = (count_d != '0);

    if (count_d == '0) begin
      out_d = '0;
    end else if ((count_after_pop == '0) && push) begin
      // Queue drains to empty this edge: new write falls straight through to the head.
      out_d = request_in;
    end else begin
      out_d = mem_q[rd_ptr_d];
    end

    if (flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      valid_d  = 1'b0;
      out_d    = '0;
      ack_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      ack_q    <= ack_d;
    end
  end

  // Storage needs no reset; the head register and count gate visibility.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_q[wr_ptr_q] <= request_in;
    end
  end

  assign issue_ack_out     = ack_q;
  assign request_out       = out_q;
  assign request_valid_out = valid_q;
  assign occupancy_out     = count_q;
  assign is_empty_out      = (count_q == '0);
  assign is_full_out       = (count_q == DepthC);
  assign almost_full_out   = (count_q >= ThreshC);

endmodule
